rgb_pwm_ctrl: RTL and testbench



---
 rtl/rgb_pwm_pkg.sv | 30 +++
 rtl/rgb_pwm_regs.sv | 89 ++++++++
 rtl/rgb_pwm_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rgb_pwm_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB LED PWM controller: register map,
// CTRL bit positions, FSM state encoding and a small helper.
package rgb_pwm_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_PRESC  = 3'd1;
   localparam logic [2:0] ADDR_DUTY0  = 3'd2;
   localparam logic [2:0] ADDR_DUTY1  = 3'd3;
   localparam logic [2:0] ADDR_DUTY2  = 3'd4;
   localparam logic [2:0] ADDR_ON_T   = 3'd5;
   localparam logic [2:0] ADDR_OFF_T  = 3'd6;
   localparam logic [2:0] ADDR_STATUS = 3'd7;

   localparam int CTRL_EN_BIT    = 7;
   localparam int CTRL_BLINK_BIT = 6;

   // Encoding is visible to software through STATUS[1:0].
   typedef enum logic [1:0] {
      ST_DISABLED  = 2'd0,
      ST_SETTLE    = 2'd1,
      ST_BLINK_ON  = 2'd2,
      ST_BLINK_OFF = 2'd3
   } state_t;

   // A programmed frame count of 0 behaves as a single frame.
   function automatic logic [7:0] frames_min1(input logic [7:0] t);
      return (t == 8'd0) ? 8'd1 : t;
   endfunction

endpackage

// File: rtl/rgb_pwm_regs.sv
// Bus-facing register file of the RGB PWM controller plus the active
// (shadow) duty registers that the PWM comparators use.
// Handshake: ledd_cs is a one-cycle strobe; a write lands in its register
// on the clock edge that samples the strobe, a read returns registered data
// on the following cycle.
module rgb_pwm_regs
   import rgb_pwm_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cs,
   input  logic            we,
   input  logic [2:0]      addr,
   input  logic [7:0]      wdata,
   input  state_t          state,
   input  logic            load,
   output logic [7:0]      rdata,
   output logic            ctrl_en,
   output logic            blink_en,
   output logic [7:0]      presc,
   output logic [7:0]      on_t,
   output logic [7:0]      off_t,
   output logic [2:0][7:0] duty_act
);

   logic [2:0][7:0] duty;
   logic [7:0]      rd_val;

   // Software-visible registers; STATUS and unknown addresses ignore writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_en  <= 1'b0;
         blink_en <= 1'b0;
         presc    <= 8'd0;
         duty     <= '0;
         on_t     <= 8'd0;
         off_t    <= 8'd0;
      end else if (cs && we) begin
         case (addr)
            ADDR_CTRL: begin
               ctrl_en  <= wdata[CTRL_EN_BIT];
               blink_en <= wdata[CTRL_BLINK_BIT];
            end
            ADDR_PRESC: presc   <= wdata;
            ADDR_DUTY0: duty[0] <= wdata;
            ADDR_DUTY1: duty[1] <= wdata;
            ADDR_DUTY2: duty[2] <= wdata;
            ADDR_ON_T:  on_t    <= wdata;
            ADDR_OFF_T: off_t   <= wdata;
            default: ;
         endcase
      end
   end

   // Active duties only change at frame boundaries so a frame is never torn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_act <= '0;
      end else if (load) begin
         duty_act <= duty;
      end
   end

   // Read mux; unimplemented bits read as zero.
   always_comb begin
      rd_val = 8'd0;
      case (addr)
         ADDR_CTRL:   rd_val = {ctrl_en, blink_en, 6'd0};
         ADDR_PRESC:  rd_val = presc;
         ADDR_DUTY0:  rd_val = duty[0];
         ADDR_DUTY1:  rd_val = duty[1];
         ADDR_DUTY2:  rd_val = duty[2];
         ADDR_ON_T:   rd_val = on_t;
         ADDR_OFF_T:  rd_val = off_t;
         ADDR_STATUS: rd_val = {6'd0, state};
         default:     rd_val = 8'd0;
      endcase
   end

   // Registered read data, updated only by a read strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= 8'd0;
      end else if (cs && !we) begin
         rdata <= rd_val;
      end
   end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// RGB LED PWM controller: enable/settle/blink FSM, PWM prescaler and frame
// counter, and the three registered duty comparators feeding the pad macro.
// rgbled_en to first PWM pulse spans SETTLE_CYC clocks: SETTLE occupies
// SETTLE_CYC-1 of them and the registered comparator adds the last one
// (SETTLE_CYC=1 still passes through one SETTLE clock, giving 2).
module rgb_pwm_ctrl
   import rgb_pwm_pkg::*;
#(
   parameter int SETTLE_CYC = 64,
   parameter int SETTLE_W   = 7
) (
   input  logic       ledd_clk,
   input  logic       ledd_rst_n,
   input  logic       ledd_cs,
   input  logic       ledd_we,
   input  logic [2:0] ledd_addr,
   input  logic [7:0] ledd_wdata,
   output logic [7:0] ledd_rdata,
   output logic [2:0] rgb_pwm,
   output logic       rgbled_en,
   output logic       ledd_on
);

   localparam int SETTLE_LAST_I = (SETTLE_CYC > 1) ? SETTLE_CYC - 2 : 0;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_LAST_I[SETTLE_W-1:0];

   state_t          state;
   state_t          state_d;
   logic            ctrl_en;
   logic            blink_en;
   logic [7:0]      presc;
   logic [7:0]      on_t;
   logic [7:0]      off_t;
   logic [2:0][7:0] duty_act;
   logic [SETTLE_W-1:0] scnt;
   logic [7:0]      psc;
   logic [7:0]      presc_act;
   logic [7:0]      fcnt;
   logic [7:0]      bcnt;
   logic [7:0]      on_lim;
   logic [7:0]      off_lim;
   logic            run;
   logic            run_next;
   logic            tick;
   logic            frame_end;
   logic            load;
   logic [2:0]      pwm_d;

   rgb_pwm_regs u_regs (
      .clk      (ledd_clk),
      .rst_n    (ledd_rst_n),
      .cs       (ledd_cs),
      .we       (ledd_we),
      .addr     (ledd_addr),
      .wdata    (ledd_wdata),
      .state    (state),
      .load     (load),
      .rdata    (ledd_rdata),
      .ctrl_en  (ctrl_en),
      .blink_en (blink_en),
      .presc    (presc),
      .on_t     (on_t),
      .off_t    (off_t),
      .duty_act (duty_act)
   );

   assign on_lim    = frames_min1(on_t);
   assign off_lim   = frames_min1(off_t);
   assign run       = (state == ST_BLINK_ON) || (state == ST_BLINK_OFF);
   assign run_next  = (state_d == ST_BLINK_ON) || (state_d == ST_BLINK_OFF);
   assign tick      = run && (psc == presc_act);
   assign frame_end = tick && (fcnt == 8'hFF);
   assign load      = frame_end || ((state == ST_SETTLE) && (state_d == ST_BLINK_ON));
   assign ledd_on   = (state == ST_BLINK_ON);

   // Next-state logic; clearing EN overrides every other event.
   always_comb begin
      state_d = state;
      case (state)
         ST_DISABLED:  if (ctrl_en) state_d = ST_SETTLE;
         ST_SETTLE:    if (scnt == SETTLE_LAST) state_d = ST_BLINK_ON;
         ST_BLINK_ON:  if (frame_end && blink_en && (bcnt >= on_lim - 8'd1))
                          state_d = ST_BLINK_OFF;
         ST_BLINK_OFF: if (frame_end && (bcnt >= off_lim - 8'd1))
                          state_d = ST_BLINK_ON;
         default:      state_d = ST_DISABLED;
      endcase
      if (!ctrl_en) state_d = ST_DISABLED;
   end

   // FSM state register.
   always_ff @(posedge ledd_clk or negedge ledd_rst_n) begin
      if (!ledd_rst_n) state <= ST_DISABLED;
      else             state <= state_d;
   end

   // Settle counter runs only while remaining in SETTLE.
   always_ff @(posedge ledd_clk or negedge ledd_rst_n) begin
      if (!ledd_rst_n) begin
         scnt <= '0;
      end else if ((state == ST_SETTLE) && (state_d == ST_SETTLE)) begin
         scnt <= scnt + 1'b1;
      end else begin
         scnt <= '0;
      end
   end

   // Prescaler and frame counter; a new PRESC is picked up at each wrap.
   always_ff @(posedge ledd_clk or negedge ledd_rst_n) begin
      if (!ledd_rst_n) begin
         psc       <= 8'd0;
         presc_act <= 8'd0;
         fcnt      <= 8'd0;
      end else if (run && run_next) begin
         if (tick) begin
            psc       <= 8'd0;
            presc_act <= presc;
            fcnt      <= fcnt + 8'd1;
         end else begin
            psc <= psc + 8'd1;
         end
      end else begin
         psc       <= 8'd0;
         presc_act <= presc;
         fcnt      <= 8'd0;
      end
   end

   // Completed-frame counter for blink timing, cleared on any state change.
   always_ff @(posedge ledd_clk or negedge ledd_rst_n) begin
      if (!ledd_rst_n) begin
         bcnt <= 8'd0;
      end else if (state_d != state) begin
         bcnt <= 8'd0;
      end else if (frame_end && ((state == ST_BLINK_OFF) || blink_en)) begin
         bcnt <= bcnt + 8'd1;
      end
   end

   // Duty comparators, gated so PWM drops together with rgbled_en.
   always_comb begin
      pwm_d = 3'b000;
      for (int i = 0; i < 3; i++) begin
         pwm_d[i] = (state == ST_BLINK_ON) && (state_d != ST_DISABLED) &&
                    (fcnt < duty_act[i]);
      end
   end

   // Registered pad-facing outputs.
   always_ff @(posedge ledd_clk or negedge ledd_rst_n) begin
      if (!ledd_rst_n) begin
         rgb_pwm   <= 3'b000;
         rgbled_en <= 1'b0;
      end else begin
         rgb_pwm   <= pwm_d;
         rgbled_en <= (state_d != ST_DISABLED);
      end
   end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Bench for rgb_pwm_ctrl: directed sequence with randomized configurations,
// every PWM cycle compared against an arithmetic frame/tick/blink model.
`timescale 1ns/1ps
module tb_rgb_pwm_ctrl;
   import rgb_pwm_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       cs;
   logic       we;
   logic [2:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic [2:0] rgb_pwm;
   logic       rgbled_en;
   logic       ledd_on;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   rgb_pwm_ctrl #(.SETTLE_CYC(64), .SETTLE_W(7)) dut (
      .ledd_clk   (clk),
      .ledd_rst_n (rst_n),
      .ledd_cs    (cs),
      .ledd_we    (we),
      .ledd_addr  (addr),
      .ledd_wdata (wdata),
      .ledd_rdata (rdata),
      .rgb_pwm    (rgb_pwm),
      .rgbled_en  (rgbled_en),
      .ledd_on    (ledd_on)
   );

   // Clock: 100 MHz, DUT active on posedge, bench samples on negedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks = n_checks + 1;
      assert (obs === expv) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      cs = 1'b0;
      d = rdata;
   endtask

   task automatic configure(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] on_t, input logic [7:0] off_t);
      bus_write(ADDR_PRESC, p);
      bus_write(ADDR_DUTY0, d0);
      bus_write(ADDR_DUTY1, d1);
      bus_write(ADDR_DUTY2, d2);
      bus_write(ADDR_ON_T, on_t);
      bus_write(ADDR_OFF_T, off_t);
   endtask

   // Enable, then check rgbled_en rises one clock later and no pulse for 64 clocks.
   // Returns positioned on the first PWM sample of frame 0.
   task automatic enable_run(input logic [7:0] ctrl_val);
      int early;
      bus_write(ADDR_CTRL, ctrl_val);
      check("en_before_rise", 32'(rgbled_en), 32'd0);
      @(negedge clk);
      check("en_rise", 32'(rgbled_en), 32'd1);
      early = 0;
      repeat (64) begin
         if (rgb_pwm !== 3'b000) early++;
         @(negedge clk);
      end
      check("settle_quiet", 32'(early), 32'd0);
   endtask

   task automatic disable_dut();
      bus_write(ADDR_CTRL, 8'h00);
      @(negedge clk);
      check("dis_pwm", 32'(rgb_pwm), 32'd0);
      check("dis_en", 32'(rgbled_en), 32'd0);
      check("dis_on", 32'(ledd_on), 32'd0);
   endtask

   // Reference model: sample j is PWM cycle j since the first frame began.
   // Frame f = j / len, tick position = (j % len) / (presc+1); a channel is
   // high when its frame is a pulsing frame and position < that frame's duty.
   // An optional DUTY0 write at sample wr_j applies from the next frame start.
   task automatic run_trace(input int nfr, input int presc, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2, input bit blink,
                            input int on_t, input int off_t, input int wr_j,
                            input logic [7:0] wr_d);
      int len, on_n, off_n, f, fn, pos, en_low, on_mism;
      int hi_cnt [3];
      int mism [3];
      logic [7:0] duty [3];
      bit ph, ph_next, expb;
      len   = 256 * (presc + 1);
      on_n  = (on_t == 0) ? 1 : on_t;
      off_n = (off_t == 0) ? 1 : off_t;
      en_low = 0; on_mism = 0;
      for (int i = 0; i < 3; i++) begin hi_cnt[i] = 0; mism[i] = 0; end
      for (int j = 0; j < nfr * len; j++) begin
         f       = j / len;
         fn      = (j + 1) / len;
         pos     = (j % len) / (presc + 1);
         ph      = !blink || ((f % (on_n + off_n)) < on_n);
         ph_next = !blink || ((fn % (on_n + off_n)) < on_n);
         duty[0] = (wr_j >= 0 && f * len > wr_j) ? wr_d : d0;
         duty[1] = d1;
         duty[2] = d2;
         for (int i = 0; i < 3; i++) begin
            expb = ph && (pos < int'(duty[i]));
            if (rgb_pwm[i] !== expb) mism[i]++;
            if (rgb_pwm[i] === 1'b1) hi_cnt[i]++;
         end
         if (rgbled_en !== 1'b1) en_low++;
         if (ledd_on !== ph_next) on_mism++;
         if ((j % len) == len - 1) begin
            for (int i = 0; i < 3; i++) begin
               check($sformatf("frame%0d_high_ch%0d", f, i), 32'(hi_cnt[i]),
                     ph ? 32'(int'(duty[i]) * (presc + 1)) : 32'd0);
               hi_cnt[i] = 0;
            end
         end
         if (j == wr_j) begin
            cs = 1'b1; we = 1'b1; addr = ADDR_DUTY0; wdata = wr_d;
         end else if (wr_j >= 0 && j == wr_j + 1) begin
            cs = 1'b0; we = 1'b0;
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++)
         check($sformatf("trace_ch%0d", i), 32'(mism[i]), 32'd0);
      check("trace_en_held", 32'(en_low), 32'd0);
      check("trace_ledd_on", 32'(on_mism), 32'd0);
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] rv;
      logic [7:0] r0, r1, r2, rw;
      int idle_bad, rp, ron, roff, rj;
      bit rb;

      cs = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pwm", 32'(rgb_pwm), 32'd0);
      check("rst_en", 32'(rgbled_en), 32'd0);
      check("rst_on", 32'(ledd_on), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      rst_n = 1'b1;

      // Idle after reset: nothing moves without a write.
      idle_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (rgb_pwm !== 3'b000 || rgbled_en !== 1'b0 || ledd_on !== 1'b0) idle_bad++;
      end
      check("idle_outputs", 32'(idle_bad), 32'd0);
      bus_read(ADDR_STATUS, rd);
      check("status_idle", 32'(rd), 32'd0);

      // Register readback, unused bits, read-only STATUS.
      bus_write(ADDR_CTRL, 8'h3F);
      bus_read(ADDR_CTRL, rd);
      check("ctrl_unused_bits", 32'(rd), 32'd0);
      rv = 8'($urandom_range(0, 255));
      bus_write(ADDR_OFF_T, rv);
      bus_read(ADDR_OFF_T, rd);
      check("off_t_readback", 32'(rd), 32'(rv));
      bus_write(ADDR_STATUS, 8'hFF);
      bus_read(ADDR_STATUS, rd);
      check("status_ro", 32'(rd), 32'd0);
      check("no_en_no_drive", 32'(rgbled_en), 32'd0);

      // STATUS shows SETTLE shortly after enable.
      bus_write(ADDR_CTRL, 8'h80);
      repeat (3) @(negedge clk);
      bus_read(ADDR_STATUS, rd);
      check("status_settle", 32'(rd), 32'd1);
      bus_read(ADDR_CTRL, rd);
      check("ctrl_readback", 32'(rd), 32'h80);
      disable_dut();

      // Basic PWM at PRESC=0.
      configure(8'd0, 8'h40, 8'h00, 8'hFF, 8'd0, 8'd0);
      enable_run(8'h80);
      run_trace(3, 0, 8'h40, 8'h00, 8'hFF, 1'b0, 0, 0, -1, 8'h00);
      bus_read(ADDR_STATUS, rd);
      check("status_blink_on", 32'(rd), 32'd2);
      check("pwm_101_before_dis", 32'(rgb_pwm), 32'b101);
      disable_dut();
      bus_read(ADDR_STATUS, rd);
      check("status_after_dis", 32'(rd), 32'd0);

      // Re-enable repeats the full settle.
      enable_run(8'h80);
      run_trace(1, 0, 8'h40, 8'h00, 8'hFF, 1'b0, 0, 0, -1, 8'h00);
      disable_dut();

      // PRESC=3: 1024-clock frames.
      configure(8'd3, 8'h80, 8'h01, 8'h00, 8'd0, 8'd0);
      enable_run(8'h80);
      run_trace(2, 3, 8'h80, 8'h01, 8'h00, 1'b0, 0, 0, -1, 8'h00);
      disable_dut();

      // Mid-frame duty write at fcnt=0x10 lands on the next frame.
      configure(8'd0, 8'h40, 8'h00, 8'hFF, 8'd0, 8'd0);
      enable_run(8'h80);
      run_trace(2, 0, 8'h40, 8'h00, 8'hFF, 1'b0, 0, 0, 15, 8'hC0);
      disable_dut();

      // Blink ON_T=2 / OFF_T=1, then STATUS inside an off frame.
      configure(8'd0, 8'h40, 8'h80, 8'hFF, 8'd2, 8'd1);
      enable_run(8'hC0);
      run_trace(5, 0, 8'h40, 8'h80, 8'hFF, 1'b1, 2, 1, -1, 8'h00);
      bus_read(ADDR_STATUS, rd);
      check("status_blink_off", 32'(rd), 32'd3);
      disable_dut();

      // ON_T=0 behaves as one frame.
      configure(8'd0, 8'h10, 8'h20, 8'h30, 8'd0, 8'd1);
      enable_run(8'hC0);
      run_trace(4, 0, 8'h10, 8'h20, 8'h30, 1'b1, 0, 1, -1, 8'h00);
      disable_dut();

      // Randomized configurations.
      for (int r = 0; r < 3; r++) begin
         rp   = $urandom_range(0, 1);
         r0   = 8'($urandom_range(0, 255));
         r1   = 8'($urandom_range(0, 255));
         r2   = 8'($urandom_range(0, 255));
         rw   = 8'($urandom_range(0, 255));
         rb   = 1'($urandom_range(0, 1));
         ron  = $urandom_range(0, 2);
         roff = $urandom_range(0, 2);
         rj   = $urandom_range(20, 256 * (rp + 1) - 20);
         configure(8'(rp), r0, r1, r2, 8'(ron), 8'(roff));
         enable_run(rb ? 8'hC0 : 8'h80);
         run_trace(3, rp, r0, r1, r2, rb, ron, roff, rj, rw);
         disable_dut();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
